// File: rtl/neuron_loader.sv
// neuron_loader: fetches weights/bias from a sync ROM, collects pixels, drives a neuron and captures its result
module neuron_loader #(
  parameter int INPUT_DATA_SIZE = 4,
  parameter int RESOLUTION      = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int NEURON_LATENCY  = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 base_addr,
  output logic [ADDR_WIDTH-1:0]                 rom_addr,
  input  logic [RESOLUTION-1:0]                 rom_data,
  input  logic [RESOLUTION-1:0]                 pix_data,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  output logic [RESOLUTION*INPUT_DATA_SIZE-1:0] input_data,
  output logic [RESOLUTION*INPUT_DATA_SIZE-1:0] weight,
  output logic [RESOLUTION-1:0]                 bias,
  input  logic [RESOLUTION-1:0]                 output_neuron,
  output logic [RESOLUTION-1:0]                 result,
  output logic                                  result_valid,
  output logic                                  busy
);
  localparam int CW = $clog2(INPUT_DATA_SIZE + 2);
  localparam int LW = $clog2(NEURON_LATENCY + 2);
  localparam logic [CW-1:0] N_C  = CW'(INPUT_DATA_SIZE);
  localparam logic [CW-1:0] N1_C = CW'(INPUT_DATA_SIZE + 1);
  localparam logic [CW-1:0] NM_C = CW'(INPUT_DATA_SIZE - 1);
  localparam logic [LW-1:0] L_C  = LW'(NEURON_LATENCY);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] acnt, rcnt, pcnt;
  logic [LW-1:0] wcnt;
  logic rd_ok, pix_fire, rom_fin, pix_fin, wait_last;

  assign pix_ready    = state == LOAD && pcnt != N_C;
  assign pix_fire     = pix_valid && pix_ready;
  assign rom_fin      = rcnt == N1_C || (rd_ok && rcnt == N_C);
  assign pix_fin      = pcnt == N_C || (pix_fire && pcnt == NM_C);
  assign wait_last    = wcnt == L_C;
  assign result_valid = state == DONE;
  assign busy         = state != IDLE;

  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;

  // next state: LOAD ends when both the ROM and pixel sides have finished
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = rom_fin && pix_fin ? WAIT : LOAD;
      WAIT:    state_nx = wait_last ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end

  // datapath: ROM addressing one word ahead of capture, pixel packing, result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr   <= '0;
      input_data <= '0;
      weight     <= '0;
      bias       <= '0;
      result     <= '0;
      acnt       <= '0;
      rcnt       <= '0;
      pcnt       <= '0;
      wcnt       <= '0;
      rd_ok      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rom_addr <= base_addr;
          acnt     <= '0;
          rcnt     <= '0;
          pcnt     <= '0;
          wcnt     <= '0;
          rd_ok    <= 1'b0;
        end
        LOAD: begin
          rd_ok <= 1'b1;
          if (acnt != N_C) begin
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
            acnt     <= acnt + CW'(1);
          end
          if (rd_ok && rcnt != N1_C) begin
            if (rcnt == N_C) bias <= rom_data;
            else weight[int'(rcnt)*RESOLUTION +: RESOLUTION] <= rom_data;
            rcnt <= rcnt + CW'(1);
          end
          if (pix_fire) begin
            input_data[int'(pcnt)*RESOLUTION +: RESOLUTION] <= pix_data;
            pcnt <= pcnt + CW'(1);
          end
        end
        WAIT:
          if (wait_last) result <= output_neuron;
          else wcnt <= wcnt + LW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_loader.sv
// tb_neuron_loader: randomized self-checking bench for neuron_loader with ROM and neuron models
module tb_neuron_loader;
  logic        clk = 0;
  logic        reset, start, pix_valid, pix_ready, result_valid, busy;
  logic [7:0]  base_addr, rom_addr, rom_data, pix_data, bias, output_neuron, result;
  logic [31:0] input_data, weight;
  logic [7:0]  rom [256];
  int passed = 0, total = 0;

  neuron_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .input_data(input_data),
    .weight(weight), .bias(bias), .output_neuron(output_neuron),
    .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] neuron_fn(input logic [31:0] x, input logic [31:0] w, input logic [7:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(x[i*8 +: 8])) * int'($signed(w[i*8 +: 8]));
    return 8'(s / 4096 + int'($signed(b)));
  endfunction

  always_ff @(posedge clk) rom_data <= rom[rom_addr];
  always_ff @(posedge clk) output_neuron <= neuron_fn(input_data, weight, bias);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_input_data"}, input_data, 0);
    chk({tag, "_weight"}, weight, 0);
    chk({tag, "_bias"}, bias, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_ctrl"}, {result_valid, pix_ready, busy}, 0);
  endtask

  task automatic run_job(input logic [7:0] base, input logic [31:0] px, input int gmin, input int gmax,
                         input bit noise, input bit hold, output logic [7:0] er);
    logic [31:0] ew;
    logic [7:0]  eb;
    int cyc = 0, pi = 0, gap = 0, fires = 0, rv_cyc = 0, pulses = 0, last_fire = 0;
    for (int i = 0; i < 4; i++) ew[i*8 +: 8] = rom[8'(base + 8'(i))];
    eb = rom[8'(base + 8'd4)];
    er = neuron_fn(px, ew, eb);
    @(negedge clk);
    start = 1;
    base_addr = base;
    @(posedge clk);
    #1 start = 0;
    while (cyc < 80 && (rv_cyc == 0 || cyc < rv_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      start = noise && rv_cyc == 0 && $urandom_range(2) == 0;
      if (pi < 4 && gap == 0) begin
        pix_valid = 1;
        pix_data = px[pi*8 +: 8];
      end else if (pi >= 4 && hold) begin
        pix_valid = 1;
        pix_data = 8'hAA;
      end else begin
        pix_valid = 0;
        if (gap > 0) gap--;
      end
      #1;
      if (pix_valid && pix_ready) begin
        fires++;
        pi++;
        last_fire = cyc;
        gap = $urandom_range(gmax, gmin);
      end
      if (cyc <= 5) chk("rom_addr_seq", rom_addr, 8'(base + 8'(cyc - 1)));
      if (result_valid) begin
        pulses++;
        if (rv_cyc == 0) rv_cyc = cyc;
      end
      chk("busy", busy, rv_cyc == 0 || cyc == rv_cyc);
    end
    start = 0;
    pix_valid = 0;
    chk("rv_seen", rv_cyc != 0, 1);
    chk("rv_latency", rv_cyc, (last_fire > 6 ? last_fire : 6) + 3);
    chk("rv_pulses", pulses, 1);
    chk("pix_fires", fires, 4);
    chk("input_data", input_data, px);
    chk("weight", weight, ew);
    chk("bias", bias, eb);
    chk("result", result, er);
  endtask

  initial begin
    logic [7:0] er;
    reset = 0; start = 0; pix_valid = 0; pix_data = 0; base_addr = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1 chk_zero("por");
    @(negedge clk) reset = 1;

    rom[8'h10] = 8'h40; rom[8'h11] = 8'h40; rom[8'h12] = 8'h40; rom[8'h13] = 8'h40; rom[8'h14] = 8'h00;
    run_job(8'h10, 32'h7F7F7F7F, 0, 0, 0, 0, er);
    chk("res_pos_const", result, 8'h07);

    run_job(8'h10, 32'h04030201, 3, 3, 0, 0, er);

    rom[8'hFE] = 8'h11; rom[8'hFF] = 8'h22; rom[8'h00] = 8'h33; rom[8'h01] = 8'h44; rom[8'h02] = 8'h05;
    run_job(8'hFE, 32'h7F7F7F7F, 0, 1, 0, 0, er);
    chk("wrap_weight", weight, 32'h44332211);
    chk("wrap_bias", bias, 8'h05);

    run_job(8'h10, 32'h7F7F7F7F, 0, 0, 1, 1, er);

    rom[8'h20] = 8'hC0; rom[8'h21] = 8'hC0; rom[8'h22] = 8'hC0; rom[8'h23] = 8'hC0; rom[8'h24] = 8'h00;
    run_job(8'h20, 32'h7F7F7F7F, 0, 0, 0, 0, er);
    chk("res_neg_const", result, 8'hF9);
    repeat (5) @(negedge clk);
    chk("result_hold", result, 8'hF9);

    @(negedge clk);
    start = 1;
    base_addr = 8'h30;
    @(negedge clk);
    start = 0;
    pix_valid = 1;
    pix_data = 8'h5A;
    repeat (2) @(negedge clk);
    pix_valid = 0;
    reset = 0;
    #1 chk_zero("abort");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_rv", result_valid, 0);
    end
    reset = 1;
    run_job(8'h30, 32'h8010F37E, 0, 2, 0, 0, er);

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      run_job(8'($urandom), $urandom, 0, 3, 1'($urandom), 1'($urandom), er);
      repeat (2) @(negedge clk);
      chk("rand_hold", result, er);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
